seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector, successor to the fixed 4-bit "1011" detector. The pattern, its length (1..PAT_W) and the overlap mode are runtime-configurable. An `in_valid` qualifier lets it sit behind a gated or bursty bit stream. A registered match pulse and an optional saturating match counter feed the status/interrupt logic of the serial front end.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, $clog2(PAT_W)+1: width of `cfg_len`.
- `CNT_W`, 16: width of `match_count`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: detection enable; low forces IDLE.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: serial data bit.
- `cfg_load` in 1: single-cycle pulse that latches `cfg_*` into shadow registers.
- `cfg_pattern` in PAT_W: pattern; bit [len-1] is the first bit received and bit 0 is the last.
- `cfg_len` in LEN_W: pattern length. 0 is treated as 1; values >PAT_W are treated as PAT_W.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `count_clr` in 1: synchronous clear of `match_count`.
- `match` out 1: registered one-cycle match pulse.
- `match_count` out CNT_W: saturating count of matches.
- `armed` out 1: high in RUN (history holds ≥len valid bits).

## Operation
- Shadow config: `pat_q`, `len_q`, `ovl_q`. Reset values are 0, 1, 1.
  - The detector uses only the shadow values. Live `cfg_*` changes have no effect until `cfg_load`.
- History: PAT_W-bit shift register. On an accepted bit, `hist <= {hist[PAT_W-2:0], in_bit}`.
- Fill counter `fill` (LEN_W bits) saturates at `len_q`.
- An accepted bit is `in_valid & enable & !cfg_load` with the FSM not in IDLE.
- FSM states:
  - IDLE: entered on reset or when `enable`=0. Clears `hist`/`fill`. Moves to FILL when `enable`=1.
  - FILL: `fill < len_q`. Each accepted bit increments `fill`. Moves to RUN when `fill` reaches `len_q`.
  - RUN: each accepted bit is compared after the shift, i.e. the low `len_q` bits of the new history against the low `len_q` bits of `pat_q`.
    - On equality, `match` pulses.
    - If `ovl_q`=0: `fill` goes to 0 and the FSM goes to FILL (history cleared).
    - If `ovl_q`=1: the FSM stays in RUN.
  - FILL also performs the compare when the accepted bit makes `fill == len_q`. This covers `len_q`=1 and the first full window.
- `cfg_load` (any state): latches config, clears `hist`/`fill`. Goes to FILL if `enable`=1, else IDLE. The bit offered in the same cycle is dropped.
- `enable` deasserted mid-pattern: the next state is IDLE and partial history is lost. `match_count` is retained.
- `match_count` increments on each match and holds at all-ones.
  - `count_clr` clears it.
  - `count_clr` together with a match gives 0 (clear wins).
- Non-accepted cycles (`in_valid`=0) hold all state. A gap never breaks a partial match.

## Timing
- Reset values: `match`=0, `match_count`=0, `armed`=0, FSM=IDLE.
- Latency: `match` is high for exactly one cycle, in the cycle after the edge that samples the final pattern bit (1 clk).
- `match_count` updates on the same edge that raises `match`.
- Minimum spacing between matches is 1 accepted bit (overlap mode, e.g. pattern "11").
- `cfg_load` takes effect on the next edge. `armed` falls on that same edge.
- Async reset mid-pattern clears everything immediately. Shadow config returns to its reset values.

## Configuration
- `SEQDET_COUNT_EN` defined: `match_count` counter and `count_clr` logic are present as described.
- Not defined: no counter flops. `match_count` is tied to 0 and `count_clr` is ignored. `match` behaviour is unchanged.

## Structure
- Package `seqdet_pkg`: FSM state enum (`SEQDET_IDLE`, `SEQDET_FILL`, `SEQDET_RUN`) and the length-clamp function.
- Sub-module `seqdet_shreg`: history shift register plus masked compare (`len`-bit window equality). It is instantiated once. The top level holds the FSM, shadow config and counter.

## Test plan
- Reset defaults, then load pattern 4'b1011, len 4, overlap 1. Stream 1,0,1,1,0,1,1 → `match` pulses after bits 4 and 7; count = 2.
- Same stream with overlap 0 → one match only (after bit 4); count = 1.
- Pattern 8'hA5, len 8, with `in_valid` gaps of 0–3 cycles between bits → single match one cycle after the 8th valid bit. Invalid cycles hold state.
- Pattern "11", len 2, overlap 1. Stream five 1s → matches on bits 2,3,4,5 (back-to-back pulses).
- Drop `enable` after 3 bits of "1011", re-enable, send 1,0,1,1 → no match on the partial, one match on the full sequence.
- With `SEQDET_COUNT_EN`:
  - Force the count to all-ones via CNT_W=2 and 5 matches → holds at 3.
  - `count_clr` coinciding with a match → 0.
  - `cfg_len`=0 behaves as len 1.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types for the parametrised serial pattern detector:
// FSM state encoding and the pattern-length clamp helper.
package seqdet_pkg;

    typedef enum logic [1:0] {
        SEQDET_IDLE = 2'd0,
        SEQDET_FILL = 2'd1,
        SEQDET_RUN  = 2'd2
    } seqdet_state_t;

    // Length 0 means a single bit; anything beyond the history depth is capped.
    function automatic int unsigned seqdet_clamp_len(input int unsigned len,
                                                     input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seqdet_shreg.sv
// History shift register for the pattern detector, plus a masked compare of
// the low `len` bits of the post-shift history against the pattern.
module seqdet_shreg #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;

    assign hist_next = {hist[PAT_W-2:0], in_bit};

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    // Evaluated on the history as it will be after this cycle's shift.
    assign hit = ((hist_next ^ pattern) & mask) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (shift) begin
            hist <= hist_next;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with registered match pulse.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    seqdet_state_t    state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] fill_inc;
    logic             accept;
    logic             hit;
    logic             hist_clr;
    logic             match_d;
    logic             match_q;

    assign accept   = in_valid & enable & ~cfg_load & (state_q != SEQDET_IDLE);
    assign fill_inc = fill_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= LEN_W'(1);
            ovl_q <= 1'b1;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= LEN_W'(seqdet_clamp_len(32'(cfg_len), PAT_W));
            ovl_q <= cfg_overlap;
        end
    end

    seqdet_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .clr     (hist_clr),
        .shift   (accept),
        .in_bit  (in_bit),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQDET_IDLE;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        hist_clr = 1'b0;
        match_d  = 1'b0;
        if (cfg_load) begin
            hist_clr = 1'b1;
            fill_d   = '0;
            state_d  = enable ? SEQDET_FILL : SEQDET_IDLE;
        end else if (!enable) begin
            hist_clr = 1'b1;
            fill_d   = '0;
            state_d  = SEQDET_IDLE;
        end else begin
            case (state_q)
                SEQDET_IDLE: begin
                    hist_clr = 1'b1;
                    fill_d   = '0;
                    state_d  = SEQDET_FILL;
                end
                SEQDET_FILL: begin
                    if (in_valid) begin
                        fill_d = fill_inc;
                        // The bit completing the first window is compared here.
                        if (fill_inc == len_q) begin
                            match_d = hit;
                            state_d = SEQDET_RUN;
                            if (hit && !ovl_q) begin
                                fill_d   = '0;
                                hist_clr = 1'b1;
                                state_d  = SEQDET_FILL;
                            end
                        end
                    end
                end
                SEQDET_RUN: begin
                    if (in_valid) begin
                        match_d = hit;
                        if (hit && !ovl_q) begin
                            fill_d   = '0;
                            hist_clr = 1'b1;
                            state_d  = SEQDET_FILL;
                        end
                    end
                end
                default: begin
                    hist_clr = 1'b1;
                    fill_d   = '0;
                    state_d  = SEQDET_IDLE;
                end
            endcase
        end
    end

    assign match = match_q;
    assign armed = (state_q == SEQDET_RUN);

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (match_d && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign match_count = count_q;
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule
